// File: rtl/hdmi_pixel_source.sv
// 640x480@60 timing generator that pulls RGB pixels from a valid/ready stream and
// drives registered, mutually aligned pixel/sync/enable outputs to the TMDS encoders.
module hdmi_pixel_source #(
   parameter int          H_ACTIVE   = 640,
   parameter int          H_FP       = 16,
   parameter int          H_SYNC     = 96,
   parameter int          H_BP       = 48,
   parameter int          V_ACTIVE   = 480,
   parameter int          V_FP       = 10,
   parameter int          V_SYNC     = 2,
   parameter int          V_BP       = 33,
   parameter logic [23:0] FILL_COLOR = 24'hFF00FF
) (
   input  logic        pixclk,
   input  logic        reset,
   input  logic [23:0] s_data,
   input  logic        s_sof,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        hSync,
   output logic        vSync,
   output logic        DrawArea,
   output logic        locked,
   output logic [15:0] underflow_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int XW      = $clog2(H_TOTAL);
   localparam int YW      = $clog2(V_TOTAL);

   localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
   localparam logic [XW-1:0] X_HS0  = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] X_HS1  = XW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
   localparam logic [YW-1:0] Y_VS0  = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] Y_VS1  = YW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

   typedef enum logic {WAIT_SOF, RUN} state_t;

   state_t        state, state_n;
   logic [XW-1:0] counter_x;
   logic [YW-1:0] counter_y;
   logic          under_seen, under_seen_n;
   logic [23:0]   rgb_n;
   logic          fill;
   logic          active, at_origin, line_end, frame_end;

   assign active    = (counter_x < X_ACT) && (counter_y < Y_ACT);
   assign at_origin = (counter_x == '0) && (counter_y == '0);
   assign line_end  = (counter_x == X_LAST);
   assign frame_end = line_end && (counter_y == Y_LAST);

   always_comb begin
      state_n      = state;
      under_seen_n = under_seen;
      s_ready      = 1'b0;
      rgb_n        = '0;
      fill         = 1'b0;
      case (state)
         WAIT_SOF: begin
            // non-SOF pixels are flushed; the SOF pixel waits for the frame origin
            s_ready      = s_valid && (!s_sof || at_origin);
            under_seen_n = 1'b0;
            if (at_origin && s_valid && s_sof) begin
               rgb_n   = s_data;
               state_n = RUN;
            end
         end
         RUN: begin
            if (active) begin
               if (s_valid && (!s_sof || at_origin)) begin
                  s_ready = 1'b1;
                  rgb_n   = s_data;
               end else begin
                  rgb_n = FILL_COLOR;
                  fill  = 1'b1;
                  if (!s_valid) under_seen_n = 1'b1;
                  else          state_n      = WAIT_SOF;  // SOF arrived early: misaligned
               end
            end
         end
         default: state_n = WAIT_SOF;
      endcase
      // a frame that starved is abandoned so the source can re-align cleanly
      if (frame_end) begin
         if (under_seen) state_n = WAIT_SOF;
         under_seen_n = 1'b0;
      end
   end

   always_ff @(posedge pixclk) begin
      if (reset) begin
         state         <= WAIT_SOF;
         counter_x     <= '0;
         counter_y     <= '0;
         under_seen    <= 1'b0;
         red           <= '0;
         green         <= '0;
         blue          <= '0;
         hSync         <= 1'b0;
         vSync         <= 1'b0;
         DrawArea      <= 1'b0;
         locked        <= 1'b0;
         underflow_cnt <= '0;
      end else begin
         state      <= state_n;
         under_seen <= under_seen_n;
         locked     <= (state_n == RUN);
         if (line_end) begin
            counter_x <= '0;
            counter_y <= (counter_y == Y_LAST) ? '0 : counter_y + YW'(1);
         end else begin
            counter_x <= counter_x + XW'(1);
         end
         {red, green, blue} <= rgb_n;
         hSync    <= (counter_x >= X_HS0) && (counter_x < X_HS1);
         vSync    <= (counter_y >= Y_VS0) && (counter_y < Y_VS1);
         DrawArea <= active;
         if (fill && (underflow_cnt != 16'hFFFF))
            underflow_cnt <= underflow_cnt + 16'd1;
      end
   end

endmodule
